// File: rtl/procesor_param.sv
// Multi-cycle accumulator processor: FETCH over req/ack, EXEC, STOP.
// Z/C/N flags, register file, and a bounded call/return link stack with fault.
module procesor_param #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_AW      = 5,
  parameter int STACK_DEPTH = 4,
  parameter int INS_W       = 5 + REG_AW + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INS_W-1:0]  imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned NREG  = 1 << REG_AW;
  localparam int          SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int          SP_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned NSTK  = 1 << SP_IW;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_STOP} state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STA,
    OP_JMP, OP_JZ,  OP_JC,  OP_CALL, OP_RET, OP_HALT, OP_R14, OP_R15
  } op_t;

  state_t             r_state;
  logic [INS_W-1:0]   r_ir;
  logic [ADDR_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_acc;
  logic               r_n;
  logic               r_c;
  logic               r_z;
  logic               r_halted;
  logic               r_fault;
  logic [SP_W-1:0]    r_sp;
  logic [DATA_W-1:0]  r_regs  [NREG];
  logic [ADDR_W-1:0]  r_stack [NSTK];

  op_t                w_op;
  logic               w_src;
  logic [REG_AW-1:0]  w_reg;
  logic [DATA_W-1:0]  w_imm;
  logic [ADDR_W-1:0]  w_target;
  logic [DATA_W-1:0]  w_arg;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [DATA_W-1:0]  w_alu_res;
  logic               w_alu_c;
  logic               w_alu_wr;
  logic               w_stk_full;
  logic               w_stk_empty;
  logic [SP_IW-1:0]   w_push_idx;
  logic [SP_IW-1:0]   w_pop_idx;

  always_comb begin
    w_op     = op_t'(r_ir[INS_W-1 -: 4]);
    w_src    = r_ir[INS_W-5];
    w_reg    = r_ir[DATA_W +: REG_AW];
    w_imm    = r_ir[DATA_W-1:0];
    w_target = w_imm[ADDR_W-1:0];
    w_arg    = w_src ? w_imm : r_regs[w_reg];
    w_pc_inc = r_pc + ADDR_W'(1);
  end

  // Stack slots are indexed modulo the array size; sp==STACK_DEPTH is caught as full.
  always_comb begin
    w_stk_full  = (r_sp == SP_W'(STACK_DEPTH));
    w_stk_empty = (r_sp == '0);
    w_push_idx  = r_sp[SP_IW-1:0];
    w_pop_idx   = w_push_idx - SP_IW'(1);
  end

  always_comb begin
    w_alu_res = r_acc;
    w_alu_c   = 1'b0;
    w_alu_wr  = 1'b1;
    case (w_op)
      OP_LDA:  w_alu_res = w_arg;
      OP_ADD:  {w_alu_c, w_alu_res} = {1'b0, r_acc} + {1'b0, w_arg};
      OP_SUB:  {w_alu_c, w_alu_res} = {1'b0, r_acc} - {1'b0, w_arg};
      OP_AND:  w_alu_res = r_acc & w_arg;
      OP_OR:   w_alu_res = r_acc | w_arg;
      OP_XOR:  w_alu_res = r_acc ^ w_arg;
      default: w_alu_wr  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_ir     <= '0;
      r_pc     <= '0;
      r_acc    <= '0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_z      <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_sp     <= '0;
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      for (int unsigned i = 0; i < NSTK; i++) r_stack[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_pc    <= w_pc_inc;
          if (w_alu_wr) begin
            r_acc <= w_alu_res;
            r_c   <= w_alu_c;
            r_z   <= (w_alu_res == '0);
            r_n   <= w_alu_res[DATA_W-1];
          end
          case (w_op)
            OP_STA: r_regs[w_reg] <= r_acc;
            OP_JMP: r_pc <= w_target;
            OP_JZ:  if (r_z) r_pc <= w_target;
            OP_JC:  if (r_c) r_pc <= w_target;
            OP_CALL: begin
              if (w_stk_full) begin
                r_pc    <= r_pc;
                r_fault <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_stack[w_push_idx] <= w_pc_inc;
                r_sp                <= r_sp + SP_W'(1);
                r_pc                <= w_target;
              end
            end
            OP_RET: begin
              if (w_stk_empty) begin
                r_pc    <= r_pc;
                r_fault <= 1'b1;
                r_state <= S_STOP;
              end else begin
                r_pc <= r_stack[w_pop_idx];
                r_sp <= r_sp - SP_W'(1);
              end
            end
            OP_HALT: begin
              r_pc     <= r_pc;
              r_halted <= 1'b1;
              r_state  <= S_STOP;
            end
            default: ;
          endcase
        end
        S_STOP: ;
        default: r_state <= S_STOP;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign acc       = r_acc;
  assign flags     = {r_n, r_c, r_z};
  assign halted    = r_halted;
  assign fault     = r_fault;

endmodule
